// File: rtl/keyboard_pkg.sv
// Shared definitions for the PS/2 set-2 key event path:
// prefix bytes, control-byte filter, decoder states and event layout.
package keyboard_pkg;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } dec_state_e;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    localparam int EVENT_W = $bits(key_event_t);

    // Keyboard responses and errors, never key codes
    function automatic logic is_ctrl_code(input logic [7:0] c);
        case (c)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_prefix(input logic [7:0] c);
        return (c == PFX_EXT) || (c == PFX_BRK) || (c == PFX_PAUSE);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous first-word-fall-through FIFO for decoded key events.
// A push while full is accepted only when a pop frees a slot.
module key_event_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scan_code_event_decoder.sv
// Folds PS/2 set-2 prefix bytes into single key events and queues
// them toward the application with a valid/ready handshake.
module scan_code_event_decoder
    import keyboard_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PAUSE_SKIP = 7
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [7:0]                  SCAN_CODE,
    input  logic                        CODE_VALID,
    output logic [7:0]                  EVENT_CODE,
    output logic                        EVENT_EXTENDED,
    output logic                        EVENT_RELEASE,
    output logic                        EVENT_VALID,
    input  logic                        EVENT_READY,
    output logic                        PAUSE_PRESSED,
    output logic                        OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);

    localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);

    dec_state_e        state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              pause_d;
    logic              fresh;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    key_event_t        push_ev;
    key_event_t        head;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        pause_d = 1'b0;
        fresh   = 1'b0;
        push    = 1'b0;
        push_ev = '0;
        if (CODE_VALID) begin
            unique case (state_q)
                ST_IDLE: fresh = 1'b1;
                ST_EXT: begin
                    unique case (1'b1)
                        SCAN_CODE == PFX_BRK:    state_d = ST_EXT_BRK;
                        SCAN_CODE == PFX_EXT:    state_d = ST_EXT;
                        is_ctrl_code(SCAN_CODE): state_d = ST_IDLE;
                        default: begin
                            push    = 1'b1;
                            push_ev = '{ext: 1'b1, rel: 1'b0, code: SCAN_CODE};
                            state_d = ST_IDLE;
                        end
                    endcase
                end
                ST_BRK, ST_EXT_BRK: begin
                    // A prefix here means a lost byte; restart decoding
                    if (is_prefix(SCAN_CODE)) begin
                        fresh = 1'b1;
                    end else begin
                        push    = 1'b1;
                        push_ev = '{ext: (state_q == ST_EXT_BRK), rel: 1'b1,
                                    code: SCAN_CODE};
                        state_d = ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    skip_d = skip_q - SKIP_W'(1);
                    if (skip_q == SKIP_W'(1)) begin
                        pause_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (fresh) begin
                unique case (1'b1)
                    SCAN_CODE == PFX_EXT:   state_d = ST_EXT;
                    SCAN_CODE == PFX_BRK:   state_d = ST_BRK;
                    SCAN_CODE == PFX_PAUSE: begin
                        state_d = ST_SKIP;
                        skip_d  = SKIP_W'(PAUSE_SKIP);
                    end
                    is_ctrl_code(SCAN_CODE): state_d = ST_IDLE;
                    default: begin
                        push    = 1'b1;
                        push_ev = '{ext: 1'b0, rel: 1'b0, code: SCAN_CODE};
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            skip_q        <= '0;
            PAUSE_PRESSED <= 1'b0;
            OVERFLOW      <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_q        <= skip_d;
            PAUSE_PRESSED <= pause_d;
            if (push && full && !pop) OVERFLOW <= 1'b1;
        end
    end

    assign EVENT_VALID = !empty;
    assign pop         = EVENT_VALID && EVENT_READY;

    key_event_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .din   (push_ev),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (FIFO_COUNT)
    );

    assign EVENT_CODE     = head.code;
    assign EVENT_EXTENDED = head.ext;
    assign EVENT_RELEASE  = head.rel;

endmodule

// File: tb/tb_scan_code_event_decoder.sv
// Bench for scan_code_event_decoder: directed scenarios plus random
// byte streams, checked every cycle against a prefix-flag event model.
module tb_scan_code_event_decoder;

    localparam int DEPTH = 8;
    localparam int SKIP  = 7;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] SCAN_CODE = 8'h00;
    logic       CODE_VALID = 1'b0;
    logic       EVENT_READY = 1'b0;
    logic [7:0] EVENT_CODE;
    logic       EVENT_EXTENDED;
    logic       EVENT_RELEASE;
    logic       EVENT_VALID;
    logic       PAUSE_PRESSED;
    logic       OVERFLOW;
    logic [3:0] FIFO_COUNT;

    int checks   = 0;
    int failures = 0;

    scan_code_event_decoder #(
        .FIFO_DEPTH (DEPTH),
        .PAUSE_SKIP (SKIP)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .SCAN_CODE      (SCAN_CODE),
        .CODE_VALID     (CODE_VALID),
        .EVENT_CODE     (EVENT_CODE),
        .EVENT_EXTENDED (EVENT_EXTENDED),
        .EVENT_RELEASE  (EVENT_RELEASE),
        .EVENT_VALID    (EVENT_VALID),
        .EVENT_READY    (EVENT_READY),
        .PAUSE_PRESSED  (PAUSE_PRESSED),
        .OVERFLOW       (OVERFLOW),
        .FIFO_COUNT     (FIFO_COUNT)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit m_ctl(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
               b == 8'hFC || b == 8'hFD || b == 8'hFE || b == 8'hFF;
    endfunction

    function automatic bit m_pfx(input logic [7:0] b);
        return b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
    endfunction

    // Model: queue of {ext,rel,code} plus "prefix seen" flags
    logic [9:0] mq[$];
    bit m_ext, m_brk, m_ovf, m_pause, started;
    int m_skip;

    function automatic void emit(input logic [9:0] ev, input bit popping);
        if (mq.size() < DEPTH || popping) mq.push_back(ev);
        else m_ovf = 1'b1;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit popping);
        if (m_skip > 0) begin
            m_skip--;
            if (m_skip == 0) m_pause = 1'b1;
            return;
        end
        if (m_brk) begin
            if (!m_pfx(b)) begin
                emit({m_ext, 1'b1, b}, popping);
                m_ext = 1'b0;
                m_brk = 1'b0;
                return;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b != 8'hE0) begin
                if (!m_ctl(b)) emit({2'b10, b}, popping);
                m_ext = 1'b0;
            end
            return;
        end
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE1) m_skip = SKIP;
        else if (!m_ctl(b)) emit({2'b00, b}, popping);
    endfunction

    always @(posedge CLK) begin
        bit popping;
        popping = 1'b0;
        if (RST) begin
            mq.delete();
            m_ext = 0; m_brk = 0; m_ovf = 0; m_pause = 0; m_skip = 0;
            started = 1'b1;
        end else begin
            popping = (mq.size() > 0) && EVENT_READY;
            m_pause = 1'b0;
            if (CODE_VALID) model_byte(SCAN_CODE, popping);
            if (popping) void'(mq.pop_front());
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("valid", EVENT_VALID, mq.size() != 0);
            chk("count", FIFO_COUNT, mq.size());
            chk("overflow", OVERFLOW, m_ovf);
            chk("pause", PAUSE_PRESSED, m_pause);
            if (mq.size() != 0)
                chk("head", {EVENT_EXTENDED, EVENT_RELEASE, EVENT_CODE}, mq[0]);
        end
    end

    task automatic do_reset();
        @(negedge CLK); #1 RST = 1'b1;
        @(negedge CLK); #1 RST = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge CLK); #1 SCAN_CODE = b; CODE_VALID = 1'b1;
        @(negedge CLK); #1 CODE_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] ctl [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA,
                                8'hFC, 8'hFD, 8'hFE, 8'hFF};
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 8'hE0;
            1: return 8'hF0;
            2: return 8'hE1;
            3: return ctl[$urandom_range(0, 7)];
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                                      8'hF0, 8'h14, 8'hF0, 8'h77};
        do_reset();
        chk("rst_valid", EVENT_VALID, 0);
        chk("rst_code", EVENT_CODE, 0);
        chk("rst_count", FIFO_COUNT, 0);
        chk("rst_ovf", OVERFLOW, 0);
        chk("rst_pause", PAUSE_PRESSED, 0);

        // make / break
        @(negedge CLK); #1 SCAN_CODE = 8'h1C; CODE_VALID = 1'b1;
        chk("make_pre_valid", EVENT_VALID, 0);
        @(negedge CLK); #1 CODE_VALID = 1'b0;
        chk("make_valid", EVENT_VALID, 1);
        chk("make_ev", {EVENT_EXTENDED, EVENT_RELEASE, EVENT_CODE}, 10'h01C);
        strobe(8'hF0);
        strobe(8'h1C);
        chk("break_count", FIFO_COUNT, 2);
        EVENT_READY = 1'b1;
        idle(1);
        chk("break_ev", {EVENT_EXTENDED, EVENT_RELEASE, EVENT_CODE}, 10'h11C);
        idle(2);

        // extended keys with a control byte in between
        EVENT_READY = 1'b0;
        strobe(8'hE0); strobe(8'h75); strobe(8'hFA);
        strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
        chk("ext_count", FIFO_COUNT, 2);
        chk("ext_ev", {EVENT_EXTENDED, EVENT_RELEASE, EVENT_CODE}, 10'h275);
        EVENT_READY = 1'b1;
        idle(1);
        chk("ext_brk_ev", {EVENT_EXTENDED, EVENT_RELEASE, EVENT_CODE}, 10'h375);
        idle(2);

        // pause sequence
        for (int i = 0; i < 8; i++) strobe(pause_seq[i]);
        chk("pause_pulse", PAUSE_PRESSED, 1);
        chk("pause_noev", FIFO_COUNT, 0);
        EVENT_READY = 1'b0;
        strobe(8'h1C);
        chk("after_pause", {EVENT_EXTENDED, EVENT_RELEASE, EVENT_CODE}, 10'h01C);
        EVENT_READY = 1'b1;
        idle(2);

        // overflow
        EVENT_READY = 1'b0;
        for (int i = 0; i < 9; i++) strobe(8'h15 + 8'(i));
        chk("ovf_count", FIFO_COUNT, 8);
        chk("ovf_flag", OVERFLOW, 1);
        chk("ovf_head", EVENT_CODE, 8'h15);
        EVENT_READY = 1'b1;
        idle(10);
        chk("ovf_drained", FIFO_COUNT, 0);

        // full with simultaneous push and pop
        do_reset();
        EVENT_READY = 1'b0;
        for (int i = 0; i < 8; i++) strobe(8'h30 + 8'(i));
        @(negedge CLK); #1 SCAN_CODE = 8'h2C; CODE_VALID = 1'b1; EVENT_READY = 1'b1;
        @(negedge CLK); #1 CODE_VALID = 1'b0; EVENT_READY = 1'b0;
        chk("full_pp_count", FIFO_COUNT, 8);
        chk("full_pp_ovf", OVERFLOW, 0);
        chk("full_pp_head", EVENT_CODE, 8'h31);
        EVENT_READY = 1'b1;
        idle(10);

        // reset mid-sequence
        strobe(8'hE0);
        strobe(8'hF0);
        do_reset();
        chk("mid_rst_count", FIFO_COUNT, 0);
        chk("mid_rst_ovf", OVERFLOW, 0);
        EVENT_READY = 1'b0;
        strobe(8'h1C);
        chk("mid_rst_ev", {EVENT_EXTENDED, EVENT_RELEASE, EVENT_CODE}, 10'h01C);
        EVENT_READY = 1'b1;
        idle(2);

        // random streams
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK); #1;
            CODE_VALID  = ($urandom_range(0, 1) == 1);
            SCAN_CODE   = pick();
            EVENT_READY = ($urandom_range(0, 9) < 4);
            RST         = ($urandom_range(0, 799) == 0);
        end
        @(negedge CLK); #1 CODE_VALID = 1'b0; RST = 1'b0; EVENT_READY = 1'b1;
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_code_event_decoder.md
Name: scan_code_event_decoder

Overview:
- Stage directly downstream of the keyboard receive/validity-check block.
- Consumes each validated 8-bit scan code strobe and folds PS/2 set-2 prefix bytes (E0 extended, F0 break, E1 pause) into single key events carrying code, extended flag and release flag.
- Filters keyboard control/response bytes.
- Buffers events in a small FIFO with a valid/ready output handshake toward the application logic (display, character mapper).

Parameters:
- FIFO_DEPTH, 8, number of buffered events; power of two, minimum 2.
- PAUSE_SKIP, 7, number of bytes discarded after an E1 prefix.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- SCAN_CODE  input  8  validated scan code from receiver; sampled only when CODE_VALID=1.
- CODE_VALID  input  1  single-cycle strobe, one per received byte.
- EVENT_CODE  output  8  key code of head event (prefixes stripped).
- EVENT_EXTENDED  output  1  head event was E0-prefixed.
- EVENT_RELEASE  output  1  head event was F0-prefixed (break).
- EVENT_VALID  output  1  FIFO not empty.
- EVENT_READY  input  1  consumer accepts head event when EVENT_VALID=1.
- PAUSE_PRESSED  output  1  one-cycle pulse when a complete E1 sequence has been skipped.
- OVERFLOW  output  1  sticky; an event was dropped because the FIFO was full.
- FIFO_COUNT  output  clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; skip counter 0; OVERFLOW cleared.
- CODE_VALID=0 cycles leave the FSM unchanged. No timeout on partial prefixes.
- FSM, advancing only on CODE_VALID:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> SKIP, counter=PAUSE_SKIP.
    - 00, AA, EE, FA, FC, FD, FE, FF -> dropped, stay IDLE.
    - Any other code -> push {code, ext=0, rel=0}, stay IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay EXT.
    - Control codes -> dropped, return to IDLE.
    - Other -> push {code, 1, 0}, go to IDLE.
  - BRK:
    - Any non-prefix code -> push {code, 0, 1}, go to IDLE.
    - A prefix byte (E0/F0/E1) -> treat as a fresh byte from IDLE (resync).
  - EXT_BRK:
    - Non-prefix code -> push {code, 1, 1}, go to IDLE.
    - Prefix byte -> resync as in BRK.
  - SKIP:
    - Each strobe decrements the counter.
    - On the strobe that brings it to 0: pulse PAUSE_PRESSED the next cycle and go to IDLE.
    - No event is pushed.
- Latency: the event is visible on EVENT_VALID/EVENT_* on the cycle after the CODE_VALID edge that completes it (registered push, first-word-fall-through output).
- Pop: occurs when EVENT_VALID && EVENT_READY at a clock edge. Head data is stable while EVENT_VALID=1 and EVENT_READY=0.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - When full, the push is accepted because the pop frees a slot.
  - When empty, the pushed event appears the next cycle; there is no bypass.
- Push while full with no pop: the event is dropped, OVERFLOW is set (held until RST), and FIFO contents are unchanged.
- Pointers wrap modulo FIFO_DEPTH. FIFO_COUNT saturates naturally at FIFO_DEPTH.
- RST asserted mid-sequence or with a non-empty FIFO: everything is flushed on that edge, and a CODE_VALID coincident with RST is ignored.

Decomposition:
- Shared package keyboard_pkg:
  - Prefix constants PFX_EXT=8'hE0, PFX_BRK=8'hF0, PFX_PAUSE=8'hE1.
  - Control-code list and an is_ctrl_code function.
  - FSM state encoding.
  - 10-bit event record layout {ext, rel, code[7:0]}.
- One natural sub-module: key_event_fifo.
  - Synchronous first-word-fall-through FIFO, parameterised width/depth.
  - Provides count, full and empty.

Test Plan:
- Plain make/break: strobes 1C, F0, 1C -> two events {1C,0,0} then {1C,0,1}; each EVENT_VALID appears 1 cycle after its completing strobe.
- Extended key: E0 75, then E0 F0 75 -> {75,1,0}, {75,1,1}; a control byte FA inserted between is dropped with no event.
- Pause: E1 14 77 E1 F0 14 F0 77 -> no events; PAUSE_PRESSED pulses once after the 8th byte; a following 1C yields {1C,0,0}.
- Backpressure/overflow (FIFO_DEPTH=8): EVENT_READY=0, 9 make codes -> FIFO_COUNT=8, OVERFLOW=1, head still the first code. Then EVENT_READY=1 drains 8 events in order.
- Full with simultaneous push/pop: FIFO full, EVENT_READY=1 on the cycle a new event completes -> count stays 8, the new event is accepted last, and OVERFLOW does not set.
- Reset mid-sequence: E0 F0, then RST for 1 cycle, then 1C -> {1C,0,0} (not extended/release); FIFO_COUNT=0 and OVERFLOW=0 right after reset.
